// File: rtl/match_control_pkg.sv
// GamePkg: shared types and widths for the match controller.
//   match_state_t : 3-bit match state encoding
//   HP_W          : width of the hit-point counters
//   ROUND_W       : width of the round-win counters
package GamePkg;
    localparam int HP_W    = 4;
    localparam int ROUND_W = 3;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_PLAY      = 3'd1,
        S_PAUSE     = 3'd2,
        S_ROUND_END = 3'd3,
        S_WIN       = 3'd4,
        S_LOSE      = 3'd5
    } match_state_t;
endpackage

// File: rtl/match_control_if.sv
// match_control_if: groups the game-side inputs and status outputs of the
// match controller.
//   select, pause              : player controls (levels)
//   player_hit, enemy_hit      : one-cycle hit pulses
//   player_shield, enemy_shield: shield active, blocks damage
//   o_state .. o_round_start   : registered match status
// master = stimulus/game side, slave = match_control.
interface match_control_if;
    import GamePkg::*;

    logic                select;
    logic                pause;
    logic                player_hit;
    logic                enemy_hit;
    logic                player_shield;
    logic                enemy_shield;
    match_state_t        o_state;
    logic                o_is_gaming;
    logic [HP_W-1:0]     o_player_hp;
    logic [HP_W-1:0]     o_enemy_hp;
    logic [ROUND_W-1:0]  o_player_rounds;
    logic [ROUND_W-1:0]  o_enemy_rounds;
    logic                o_player_invuln;
    logic                o_enemy_invuln;
    logic                o_round_start;

    modport master (
        output select, pause, player_hit, enemy_hit, player_shield, enemy_shield,
        input  o_state, o_is_gaming, o_player_hp, o_enemy_hp, o_player_rounds,
               o_enemy_rounds, o_player_invuln, o_enemy_invuln, o_round_start
    );

    modport slave (
        input  select, pause, player_hit, enemy_hit, player_shield, enemy_shield,
        output o_state, o_is_gaming, o_player_hp, o_enemy_hp, o_player_rounds,
               o_enemy_rounds, o_player_invuln, o_enemy_invuln, o_round_start
    );
endinterface

// File: rtl/match_control_invuln_timer.sv
// invuln_timer: per-side invulnerability down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear the window (round start)
//   load_i     : a damaging hit landed; (re)start the window
//   run_i      : count down this cycle (only while playing)
//   active_o   : window active (counter nonzero), decoded from the register
module invuln_timer #(
    parameter int IFRAME_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic run_i,
    output logic active_o
);
    localparam int              CNT_W    = $clog2(IFRAME_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IFRAME_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_LOAD;
        end else if (run_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);
endmodule

// File: rtl/match_control.sv
// match_control: round/match state machine for a two-sided shooter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : match_control_if.slave (controls, hits, shields, status)
// Optional feature: define MATCH_CONTROL_PAUSE_EN to build the pause
// edge detector and the S_PAUSE state; otherwise pause is ignored.
module match_control
    import GamePkg::*;
#(
    parameter int MAX_HP           = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int IFRAME_CYCLES    = 4,
    parameter int ROUND_GAP_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    match_control_if.slave  bus
);
    localparam int                 GAP_W    = $clog2(ROUND_GAP_CYCLES + 1);
    localparam logic [HP_W-1:0]    HP_FULL  = HP_W'(MAX_HP);
    localparam logic [ROUND_W-1:0] RND_WIN  = ROUND_W'(ROUNDS_TO_WIN);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(ROUND_GAP_CYCLES);

    match_state_t       state_q, state_d;
    logic [HP_W-1:0]    p_hp_q, p_hp_d, e_hp_q, e_hp_d;
    logic [ROUND_W-1:0] p_rnd_q, p_rnd_d, e_rnd_q, e_rnd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               round_start_q, round_start_d;
    logic               p_inv, e_inv, p_load, e_load, inv_clr, inv_run;
    logic               p_dmg, e_dmg, pause_edge;

    function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] r);
        return (r >= RND_WIN) ? r : r + ROUND_W'(1);
    endfunction

`ifdef MATCH_CONTROL_PAUSE_EN
    logic pause_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pause_q <= 1'b0;
        else        pause_q <= bus.pause;
    end
    assign pause_edge = bus.pause & ~pause_q;
`else
    assign pause_edge = 1'b0;
`endif

    // A hit only counts if it is unshielded, outside the i-frame window and
    // the side still has HP left.
    assign p_dmg   = bus.player_hit && !bus.player_shield && !p_inv && (p_hp_q != '0);
    assign e_dmg   = bus.enemy_hit  && !bus.enemy_shield  && !e_inv && (e_hp_q != '0);
    assign inv_run = (state_q == S_PLAY);

    always_comb begin
        state_d       = state_q;
        p_hp_d        = p_hp_q;
        e_hp_d        = e_hp_q;
        p_rnd_d       = p_rnd_q;
        e_rnd_d       = e_rnd_q;
        gap_d         = gap_q;
        round_start_d = 1'b0;
        p_load        = 1'b0;
        e_load        = 1'b0;
        inv_clr       = 1'b0;
        case (state_q)
            S_START: begin
                if (bus.select) begin
                    state_d       = S_PLAY;
                    p_hp_d        = HP_FULL;
                    e_hp_d        = HP_FULL;
                    p_rnd_d       = '0;
                    e_rnd_d       = '0;
                    inv_clr       = 1'b1;
                    round_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                // Round end is judged on registered HP, so a simultaneous
                // knock-out on both sides lands here together as a draw.
                if (p_hp_q == '0 || e_hp_q == '0) begin
                    state_d = S_ROUND_END;
                    gap_d   = GAP_LOAD;
                    if (p_hp_q == '0 && e_hp_q != '0) e_rnd_d = sat_inc(e_rnd_q);
                    if (e_hp_q == '0 && p_hp_q != '0) p_rnd_d = sat_inc(p_rnd_q);
                end else begin
                    if (pause_edge) state_d = S_PAUSE;
                    if (p_dmg) begin
                        p_hp_d = p_hp_q - HP_W'(1);
                        p_load = 1'b1;
                    end
                    if (e_dmg) begin
                        e_hp_d = e_hp_q - HP_W'(1);
                        e_load = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (pause_edge) state_d = S_PLAY;
            end
            S_ROUND_END: begin
                // Gap counts GAP_LOAD..1, giving exactly ROUND_GAP_CYCLES cycles.
                if (gap_q <= GAP_W'(1)) begin
                    gap_d = '0;
                    if (p_rnd_q == RND_WIN) begin
                        state_d = S_WIN;
                    end else if (e_rnd_q == RND_WIN) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d       = S_PLAY;
                        p_hp_d        = HP_FULL;
                        e_hp_d        = HP_FULL;
                        inv_clr       = 1'b1;
                        round_start_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_WIN, S_LOSE: begin
                if (bus.select) state_d = S_START;
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_START;
            p_hp_q        <= HP_FULL;
            e_hp_q        <= HP_FULL;
            p_rnd_q       <= '0;
            e_rnd_q       <= '0;
            gap_q         <= '0;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_hp_q        <= p_hp_d;
            e_hp_q        <= e_hp_d;
            p_rnd_q       <= p_rnd_d;
            e_rnd_q       <= e_rnd_d;
            gap_q         <= gap_d;
            round_start_q <= round_start_d;
        end
    end

    invuln_timer #(.IFRAME_CYCLES(IFRAME_CYCLES)) u_player_iframe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (inv_clr),
        .load_i   (p_load),
        .run_i    (inv_run),
        .active_o (p_inv)
    );

    invuln_timer #(.IFRAME_CYCLES(IFRAME_CYCLES)) u_enemy_iframe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (inv_clr),
        .load_i   (e_load),
        .run_i    (inv_run),
        .active_o (e_inv)
    );

    assign bus.o_state         = state_q;
    assign bus.o_is_gaming     = (state_q == S_PLAY);
    assign bus.o_player_hp     = p_hp_q;
    assign bus.o_enemy_hp      = e_hp_q;
    assign bus.o_player_rounds = p_rnd_q;
    assign bus.o_enemy_rounds  = e_rnd_q;
    assign bus.o_player_invuln = p_inv;
    assign bus.o_enemy_invuln  = e_inv;
    assign bus.o_round_start   = round_start_q;
endmodule

// File: tb/tb_match_control.sv
// Directed bench for match_control with default parameters
// (MAX_HP 3, ROUNDS_TO_WIN 2, IFRAME_CYCLES 4, ROUND_GAP_CYCLES 8).
module tb_match_control;
    localparam int ST_START = 0, ST_PLAY = 1, ST_PAUSE = 2;
    localparam int ST_RE = 3, ST_WIN = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;

    match_control_if bus();

    match_control #(
        .MAX_HP           (3),
        .ROUNDS_TO_WIN    (2),
        .IFRAME_CYCLES    (4),
        .ROUND_GAP_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic hit(input bit p, input bit e);
        bus.player_hit = p;
        bus.enemy_hit  = e;
        tick();
        bus.player_hit = 1'b0;
        bus.enemy_hit  = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.select        = 1'b0;
        bus.pause         = 1'b0;
        bus.player_hit    = 1'b0;
        bus.enemy_hit     = 1'b0;
        bus.player_shield = 1'b0;
        bus.enemy_shield  = 1'b0;
        repeat (2) tick();
        chk("rst_state", int'(bus.o_state), ST_START);
        chk("rst_php", int'(bus.o_player_hp), 3);
        chk("rst_ehp", int'(bus.o_enemy_hp), 3);
        chk("rst_prnd", int'(bus.o_player_rounds), 0);
        chk("rst_pinv", int'(bus.o_player_invuln), 0);
        chk("rst_rstart", int'(bus.o_round_start), 0);
        chk("rst_gaming", int'(bus.o_is_gaming), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_state", int'(bus.o_state), ST_START);

        // Start
        bus.select = 1'b1;
        tick();
        bus.select = 1'b0;
        chk("start_state", int'(bus.o_state), ST_PLAY);
        chk("start_pulse", int'(bus.o_round_start), 1);
        chk("start_gaming", int'(bus.o_is_gaming), 1);
        tick();
        chk("start_pulse_end", int'(bus.o_round_start), 0);

        // I-frames
        hit(1, 0);
        chk("if_hp_a", int'(bus.o_player_hp), 2);
        chk("if_inv_a", int'(bus.o_player_invuln), 1);
        tick();
        hit(1, 0);
        chk("if_hp_ignored", int'(bus.o_player_hp), 2);
        tick();
        chk("if_inv_still", int'(bus.o_player_invuln), 1);
        tick();
        chk("if_inv_done", int'(bus.o_player_invuln), 0);
        hit(1, 0);
        chk("if_hp_b", int'(bus.o_player_hp), 1);
        repeat (4) tick();

        // Shield
        bus.enemy_shield = 1'b1;
        hit(0, 1);
        bus.enemy_shield = 1'b0;
        chk("sh_ehp", int'(bus.o_enemy_hp), 3);
        chk("sh_einv", int'(bus.o_enemy_invuln), 0);

        // Round 1: player wins
        hit(0, 1); repeat (4) tick();
        hit(0, 1); repeat (4) tick();
        hit(0, 1);
        chk("r1_ehp0", int'(bus.o_enemy_hp), 0);
        chk("r1_still_play", int'(bus.o_state), ST_PLAY);
        tick();
        chk("r1_re", int'(bus.o_state), ST_RE);
        chk("r1_prnd", int'(bus.o_player_rounds), 1);
        chk("r1_ernd", int'(bus.o_enemy_rounds), 0);
        hit(1, 0);
        chk("re_hit_ignored", int'(bus.o_player_hp), 1);
        repeat (6) tick();
        chk("r1_gap7", int'(bus.o_state), ST_RE);
        tick();
        chk("r1_resume", int'(bus.o_state), ST_PLAY);
        chk("r1_pulse", int'(bus.o_round_start), 1);
        chk("r1_php", int'(bus.o_player_hp), 3);
        chk("r1_ehp", int'(bus.o_enemy_hp), 3);
        chk("r1_einv", int'(bus.o_enemy_invuln), 0);

        // Round 2: player wins the match
        hit(0, 1); repeat (4) tick();
        hit(0, 1); repeat (4) tick();
        hit(0, 1);
        tick();
        chk("r2_re", int'(bus.o_state), ST_RE);
        chk("r2_prnd", int'(bus.o_player_rounds), 2);
        repeat (7) tick();
        chk("r2_gap7", int'(bus.o_state), ST_RE);
        tick();
        chk("r2_win", int'(bus.o_state), ST_WIN);
        chk("r2_no_pulse", int'(bus.o_round_start), 0);
        bus.select = 1'b1;
        tick();
        bus.select = 1'b0;
        chk("win_to_start", int'(bus.o_state), ST_START);
        chk("start_hold_prnd", int'(bus.o_player_rounds), 2);
        chk("start_hold_ehp", int'(bus.o_enemy_hp), 0);

        // Draw
        bus.select = 1'b1;
        tick();
        bus.select = 1'b0;
        chk("m2_prnd_clr", int'(bus.o_player_rounds), 0);
        chk("m2_ehp", int'(bus.o_enemy_hp), 3);
        hit(1, 1); repeat (4) tick();
        hit(1, 1); repeat (4) tick();
        chk("dr_php1", int'(bus.o_player_hp), 1);
        chk("dr_ehp1", int'(bus.o_enemy_hp), 1);
        hit(1, 1);
        tick();
        chk("dr_re", int'(bus.o_state), ST_RE);
        chk("dr_prnd", int'(bus.o_player_rounds), 0);
        chk("dr_ernd", int'(bus.o_enemy_rounds), 0);
        repeat (8) tick();
        chk("dr_resume", int'(bus.o_state), ST_PLAY);
        chk("dr_php", int'(bus.o_player_hp), 3);
        chk("dr_ehp", int'(bus.o_enemy_hp), 3);

        // Enemy takes a round
        hit(1, 0); repeat (4) tick();
        hit(1, 0); repeat (4) tick();
        hit(1, 0);
        tick();
        chk("el_re", int'(bus.o_state), ST_RE);
        chk("el_ernd", int'(bus.o_enemy_rounds), 1);
        chk("el_prnd", int'(bus.o_player_rounds), 0);
        repeat (8) tick();
        chk("el_resume", int'(bus.o_state), ST_PLAY);

        // Pause mid-i-frame
        hit(1, 0);
        chk("pz_php", int'(bus.o_player_hp), 2);
        tick();
        bus.pause = 1'b1;
        tick();
`ifdef MATCH_CONTROL_PAUSE_EN
        chk("pz_state", int'(bus.o_state), ST_PAUSE);
        chk("pz_gaming", int'(bus.o_is_gaming), 0);
        bus.player_hit = 1'b1;
        repeat (20) tick();
        bus.player_hit = 1'b0;
        chk("pz_held_state", int'(bus.o_state), ST_PAUSE);
        chk("pz_held_inv", int'(bus.o_player_invuln), 1);
        chk("pz_held_hp", int'(bus.o_player_hp), 2);
        bus.pause = 1'b0;
        tick();
        bus.pause = 1'b1;
        tick();
        chk("pz_resume", int'(bus.o_state), ST_PLAY);
        chk("pz_no_pulse", int'(bus.o_round_start), 0);
        tick();
        chk("pz_inv_rem", int'(bus.o_player_invuln), 1);
        tick();
        chk("pz_inv_end", int'(bus.o_player_invuln), 0);
`else
        chk("np_state", int'(bus.o_state), ST_PLAY);
        chk("np_gaming", int'(bus.o_is_gaming), 1);
        repeat (20) tick();
        chk("np_state_late", int'(bus.o_state), ST_PLAY);
        chk("np_inv_end", int'(bus.o_player_invuln), 0);
        chk("np_hp", int'(bus.o_player_hp), 2);
`endif
        bus.pause = 1'b0;

        // Asynchronous reset mid-round
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.o_state), ST_START);
        chk("arst_php", int'(bus.o_player_hp), 3);
        chk("arst_ernd", int'(bus.o_enemy_rounds), 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("arst_no_pulse", int'(bus.o_round_start), 0);
        chk("arst_idle", int'(bus.o_state), ST_START);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/match_control.md
MATCH_CONTROL -- requirements
Module: match_control

Interface
REQ-001 SHALL provide parameter MAX_HP, default 3: HP loaded at each round start, range 1..15.
REQ-002 SHALL provide parameter ROUNDS_TO_WIN, default 2: round wins needed for a match win, range 1..7.
REQ-003 SHALL provide parameter IFRAME_CYCLES, default 4: invulnerability cycles after a damaging hit, at least 1.
REQ-004 SHALL provide parameter ROUND_GAP_CYCLES, default 8: cycles spent in S_ROUND_END, at least 1.
REQ-005 clk  input  1  single clock, all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 select  input  1  level; start, or acknowledge the result.
REQ-008 pause  input  1  level; toggles pause on its rising edge.
REQ-009 player_hit, enemy_hit  input  1 each  one-cycle hit pulses from the bullet blocks.
REQ-010 player_shield, enemy_shield  input  1 each  shield active; blocks damage.
REQ-011 o_state  output  3  current match_state_t.
REQ-012 o_is_gaming  output  1  high only in S_PLAY.
REQ-013 o_player_hp, o_enemy_hp  output  4 each  current HP.
REQ-014 o_player_rounds, o_enemy_rounds  output  3 each  rounds won so far.
REQ-015 o_player_invuln, o_enemy_invuln  output  1 each  invulnerability window active.
REQ-016 o_round_start  output  1  one-cycle pulse on each entry to S_PLAY from S_START or S_ROUND_END.

Function
REQ-017 States: S_START, S_PLAY, S_PAUSE, S_ROUND_END, S_WIN, S_LOSE.
REQ-018 S_START: on select, go to S_PLAY; HP = MAX_HP, rounds = 0, invuln cleared, o_round_start pulses.
REQ-019 Damage rule in S_PLAY: hp decrements by 1 when hit && !shield && !invuln && hp!=0.
REQ-020 Invulnerability: a decrement loads that side's counter with IFRAME_CYCLES; invuln is high while the counter is nonzero; the counter decrements only in S_PLAY.
REQ-021 Hits arriving in any state other than S_PLAY, or while the side is shielded or invulnerable, SHALL be ignored.
REQ-022 Registered HP reaching 0 in S_PLAY: go to S_ROUND_END; the opponent's rounds increment by 1, saturating at ROUNDS_TO_WIN.
REQ-023 Both HP reaching 0 in the same cycle is a draw: no round counter changes.
REQ-024 S_ROUND_END lasts exactly ROUND_GAP_CYCLES cycles; the gap counter is loaded on entry.
REQ-025 At gap expiry: player_rounds==ROUNDS_TO_WIN goes to S_WIN; enemy_rounds==ROUNDS_TO_WIN goes to S_LOSE.
REQ-026 At gap expiry with no match winner: go to S_PLAY, reload both HP to MAX_HP, clear invuln, pulse o_round_start.
REQ-027 S_WIN and S_LOSE: on select, go to S_START; HP and rounds hold their values until the next start.
REQ-028 Pause, when compiled in: a pause rising edge in S_PLAY goes to S_PAUSE; the next pause rising edge returns to S_PLAY.
REQ-029 S_PAUSE freezes HP, rounds and invuln counters; o_is_gaming is 0; o_round_start does not pulse on resume.
REQ-030 All outputs SHALL be registered or decoded directly from registers, with no combinational input-to-output path.

Reset
REQ-031 rst_n low: state S_START; HP = MAX_HP; rounds 0; invuln 0; gap counter 0; o_round_start 0; pause edge detector 0.
REQ-032 Reset asserted mid-round or mid-gap SHALL abort immediately, with no pulse on release.

Configuration
REQ-033 Macro MATCH_CONTROL_PAUSE_EN defined: REQ-028 and REQ-029 apply.
REQ-034 Macro MATCH_CONTROL_PAUSE_EN undefined: the pause input is ignored, S_PAUSE is unreachable, and the edge detector is not built.

Structure
REQ-035 GamePkg SHALL hold the match_state_t enum (3 bits), the HP_W=4 and ROUND_W=3 widths, and the state encodings.
REQ-036 Sub-module invuln_timer SHALL hold the per-side down-counter, with inputs load and run and output active; it is instantiated twice.

Verification
REQ-037 Start: select in S_START -> S_PLAY next cycle, HP 3/3, o_round_start high 1 cycle.
REQ-038 I-frames: player_hit at t and t+2 -> player HP 3 then 2; hit at t+2 ignored; a new hit after 4 PLAY cycles -> HP 1.
REQ-039 Shield: enemy_hit with enemy_shield=1 -> enemy HP unchanged, o_enemy_invuln stays 0.
REQ-040 Match: enemy HP driven to 0 twice -> player_rounds 1 then 2; after the second gap of 8 cycles -> S_WIN; select -> S_START.
REQ-041 Draw: both sides at HP 1, both hit in the same cycle -> S_ROUND_END, rounds unchanged, S_PLAY after 8 cycles with HP 3/3.
REQ-042 Pause with macro defined: pause edge mid-i-frame -> S_PAUSE, invuln held for 20 cycles; second edge -> resume with the remaining count. With macro undefined: pause has no effect.
